// File: rtl/p1_pkg.sv
// Protocol-1 receive constants, parser state encoding and a saturating counter helper.
package p1_pkg;

    localparam logic [7:0]  P1_SYNC0       = 8'hEF;
    localparam logic [7:0]  P1_SYNC1       = 8'hFE;
    localparam logic [7:0]  P1_CMD_DATA    = 8'h01;
    localparam logic [7:0]  P1_CMD_DISC    = 8'h02;
    localparam logic [7:0]  P1_CMD_START   = 8'h04;
    localparam logic [7:0]  P1_EP2         = 8'h02;
    localparam logic [7:0]  P1_FRAME_SYNC  = 8'h7F;
    localparam int unsigned P1_FRAME_BYTES = 512;
    localparam int unsigned P1_SYNC_BYTES  = 3;

    typedef enum logic [3:0] {
        P1_IDLE,
        P1_HDR,
        P1_CMD,
        P1_EP,
        P1_SEQ,
        P1_FSYNC,
        P1_FDATA,
        P1_SKIP,
        P1_DISCOVERY,
        P1_START,
        P1_DISCARD
    } p1_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/p1_byte_packer.sv
// Packs frame bytes into FIFO words. push_sync loads the three validated 7F sync bytes at once.
module p1_byte_packer
    import p1_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 push_sync,
    input  logic                 flush,
    input  logic [7:0]           in_byte,
    output logic [OUT_WIDTH-1:0] word,
    output logic                 word_wr,
    output logic                 word_sof
);

    if (OUT_WIDTH == 32) begin : g_w32
        // Big-endian accumulator: oldest byte ends up in [31:24].
        logic [23:0] acc_q;
        logic [1:0]  cnt_q;
        logic        sof_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                sof_q    <= 1'b0;
                word     <= '0;
                word_wr  <= 1'b0;
                word_sof <= 1'b0;
            end else begin
                word_wr  <= 1'b0;
                word_sof <= 1'b0;
                if (flush) begin
                    cnt_q <= '0;
                    sof_q <= 1'b0;
                end else if (push_sync) begin
                    acc_q <= {P1_FRAME_SYNC, P1_FRAME_SYNC, P1_FRAME_SYNC};
                    cnt_q <= 2'd3;
                    sof_q <= 1'b1;
                end else if (push) begin
                    if (cnt_q == 2'd3) begin
                        word     <= OUT_WIDTH'({acc_q, in_byte});
                        word_wr  <= 1'b1;
                        word_sof <= sof_q;
                        sof_q    <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        acc_q <= {acc_q[15:0], in_byte};
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
            end
        end
    end else begin : g_w8
        // Sync bytes are released over three cycles after the check, so data runs two stages behind.
        logic [1:0] pend_q;
        logic [7:0] d0_q, d1_q;
        logic       v0_q, v1_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_q   <= '0;
                d0_q     <= '0;
                d1_q     <= '0;
                v0_q     <= 1'b0;
                v1_q     <= 1'b0;
                word     <= '0;
                word_wr  <= 1'b0;
                word_sof <= 1'b0;
            end else begin
                word_wr  <= 1'b0;
                word_sof <= 1'b0;
                d0_q     <= in_byte;
                v0_q     <= push;
                d1_q     <= d0_q;
                v1_q     <= v0_q;
                if (push_sync) begin
                    word     <= OUT_WIDTH'(P1_FRAME_SYNC);
                    word_wr  <= 1'b1;
                    word_sof <= 1'b1;
                    pend_q   <= 2'd2;
                end else if (pend_q != 2'd0) begin
                    word    <= OUT_WIDTH'(P1_FRAME_SYNC);
                    word_wr <= 1'b1;
                    pend_q  <= pend_q - 2'd1;
                end else if (v1_q) begin
                    word    <= OUT_WIDTH'(d1_q);
                    word_wr <= 1'b1;
                end
                if (flush) begin
                    pend_q <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/p1_rx_parser.sv
// Protocol-1 UDP payload parser: discovery, start/stop and EP2 frame extraction with
// sequence/sync checking feeding the Rx FIFO.
module p1_rx_parser
    import p1_pkg::*;
#(
    parameter logic [15:0] DATA_PORT      = 16'd1024,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned FRAMES_PER_PKT = 2,
    parameter int unsigned SEQ_CHECK      = 1
) (
    input  logic                 rx_clock,
    input  logic                 reset_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic [15:0]          to_port,
    input  logic                 broadcast,
    input  logic                 dst_unreachable,
    output logic                 run,
    output logic                 wide_spectrum,
    output logic                 discovery_reply,
    output logic [OUT_WIDTH-1:0] fifo_data,
    output logic                 fifo_wr,
    output logic                 fifo_sof,
    output logic [15:0]          seq_err_cnt,
    output logic [15:0]          sync_err_cnt
);

    localparam logic [8:0] LAST_BYTE  = 9'(P1_FRAME_BYTES - 1);
    localparam logic [8:0] LAST_SYNC  = 9'(P1_SYNC_BYTES - 1);
    localparam logic [1:0] LAST_FRAME = 2'(FRAMES_PER_PKT - 1);

    p1_state_t   state_q, state_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  frame_cnt_q, frame_cnt_d;
    logic        sync_ok_q, sync_ok_d;
    logic [23:0] seq_shift_q;
    logic [31:0] last_seq_q;
    logic        seq_valid_q;
    logic [31:0] seq_new;
    logic        push, push_sync, flush, disc_hit, start_hit, seq_done, sync_bad;

    assign seq_new = {seq_shift_q, rx_data};

    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= P1_IDLE;
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
            sync_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sync_ok_q   <= sync_ok_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        sync_ok_d   = sync_ok_q;
        push        = 1'b0;
        push_sync   = 1'b0;
        flush       = 1'b0;
        disc_hit    = 1'b0;
        start_hit   = 1'b0;
        seq_done    = 1'b0;
        sync_bad    = 1'b0;
        if (!rx_valid) begin
            state_d = P1_IDLE;
            flush   = (state_q == P1_FSYNC) || (state_q == P1_FDATA) || (state_q == P1_SKIP);
        end else begin
            unique case (state_q)
                P1_IDLE: state_d = (to_port == DATA_PORT && rx_data == P1_SYNC0) ? P1_HDR : P1_DISCARD;
                P1_HDR:  state_d = (rx_data == P1_SYNC1) ? P1_CMD : P1_DISCARD;
                // Broadcast packets may only carry a discovery request.
                P1_CMD: begin
                    state_d = P1_DISCARD;
                    if (rx_data == P1_CMD_DISC) begin
                        state_d  = P1_DISCOVERY;
                        disc_hit = 1'b1;
                    end else if (!broadcast && rx_data == P1_CMD_START) begin
                        state_d = P1_START;
                    end else if (!broadcast && rx_data == P1_CMD_DATA) begin
                        state_d = P1_EP;
                    end
                end
                P1_DISCOVERY: state_d = P1_DISCARD;
                P1_START: begin
                    start_hit = 1'b1;
                    state_d   = P1_DISCARD;
                end
                P1_EP: begin
                    state_d    = (rx_data == P1_EP2) ? P1_SEQ : P1_DISCARD;
                    byte_cnt_d = '0;
                end
                P1_SEQ: begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q == 9'd3) begin
                        seq_done    = 1'b1;
                        state_d     = P1_FSYNC;
                        byte_cnt_d  = '0;
                        frame_cnt_d = '0;
                        sync_ok_d   = 1'b1;
                    end
                end
                P1_FSYNC: begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    sync_ok_d  = sync_ok_q && (rx_data == P1_FRAME_SYNC);
                    if (byte_cnt_q == LAST_SYNC) begin
                        push_sync = sync_ok_d;
                        sync_bad  = !sync_ok_d;
                        state_d   = sync_ok_d ? P1_FDATA : P1_SKIP;
                    end
                end
                P1_FDATA, P1_SKIP: begin
                    push       = (state_q == P1_FDATA);
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        sync_ok_d  = 1'b1;
                        if (frame_cnt_q == LAST_FRAME) begin
                            state_d = P1_DISCARD;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 2'd1;
                            state_d     = P1_FSYNC;
                        end
                    end
                end
                P1_DISCARD: state_d = P1_DISCARD;
                default:    state_d = P1_IDLE;
            endcase
        end
    end

    // Control flags, sequence tracking and saturating error counters.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            run             <= 1'b0;
            wide_spectrum   <= 1'b0;
            discovery_reply <= 1'b0;
            seq_shift_q     <= '0;
            last_seq_q      <= '0;
            seq_valid_q     <= 1'b0;
            seq_err_cnt     <= '0;
            sync_err_cnt    <= '0;
        end else begin
            discovery_reply <= disc_hit;
            if (dst_unreachable) begin
                run <= 1'b0;
            end else if (start_hit) begin
                run <= rx_data[0];
            end
            if (start_hit) begin
                wide_spectrum <= rx_data[1];
            end
            if (rx_valid && state_q == P1_SEQ) begin
                seq_shift_q <= seq_new[23:0];
            end
            if (seq_done) begin
                last_seq_q  <= seq_new;
                seq_valid_q <= 1'b1;
                if (SEQ_CHECK != 0 && seq_valid_q && seq_new != last_seq_q + 32'd1) begin
                    seq_err_cnt <= sat_inc16(seq_err_cnt);
                end
            end
            if (sync_bad) begin
                sync_err_cnt <= sat_inc16(sync_err_cnt);
            end
        end
    end

    p1_byte_packer #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_packer (
        .clk       (rx_clock),
        .rst_n     (reset_n),
        .push      (push),
        .push_sync (push_sync),
        .flush     (flush),
        .in_byte   (rx_data),
        .word      (fifo_data),
        .word_wr   (fifo_wr),
        .word_sof  (fifo_sof)
    );

endmodule

// File: tb/tb_p1_rx_parser.sv
// Scoreboard bench for p1_rx_parser (OUT_WIDTH=32, two frames per packet).
`timescale 1ns/1ps
module tb_p1_rx_parser;

    localparam logic [15:0] PORT = 16'd1024;
    localparam int          FPP  = 2;

    typedef byte unsigned bq_t[$];
    typedef struct {
        logic [31:0] data;
        logic        sof;
    } exp_t;

    logic        rx_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] to_port = 16'h0000;
    logic        broadcast = 1'b0;
    logic        dst_unreachable = 1'b0;
    logic        run, wide_spectrum, discovery_reply, fifo_wr, fifo_sof;
    logic [31:0] fifo_data;
    logic [15:0] seq_err_cnt, sync_err_cnt;

    p1_rx_parser #(
        .DATA_PORT      (PORT),
        .OUT_WIDTH      (32),
        .FRAMES_PER_PKT (FPP),
        .SEQ_CHECK      (1)
    ) dut (
        .rx_clock        (rx_clock),
        .reset_n         (reset_n),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .to_port         (to_port),
        .broadcast       (broadcast),
        .dst_unreachable (dst_unreachable),
        .run             (run),
        .wide_spectrum   (wide_spectrum),
        .discovery_reply (discovery_reply),
        .fifo_data       (fifo_data),
        .fifo_wr         (fifo_wr),
        .fifo_sof        (fifo_sof),
        .seq_err_cnt     (seq_err_cnt),
        .sync_err_cnt    (sync_err_cnt)
    );

    always #5 rx_clock = ~rx_clock;

    int   n_vec = 0;
    int   n_miss = 0;
    exp_t exp_q[$];
    int   wr_seen = 0, sof_seen = 0, disc_seen = 0;

    // Reference model state
    bit          have_last = 1'b0;
    logic [31:0] last_seq = '0;
    int          exp_seq_err = 0, exp_sync_err = 0, exp_wr = 0, exp_sof = 0, exp_disc = 0;
    logic        exp_run = 1'b0, exp_wide = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write is popped against the model queue.
    always @(negedge rx_clock) begin
        exp_t e;
        if (reset_n) begin
            if (discovery_reply) disc_seen++;
            if (fifo_wr) begin
                wr_seen++;
                if (fifo_sof) sof_seen++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL fifo_word: unexpected write %h sof %b", fifo_data, fifo_sof);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_data !== e.data || fifo_sof !== e.sof) begin
                        n_miss++;
                        $display("FAIL fifo_word: got %h/sof %b, expected %h/sof %b",
                                 fifo_data, fifo_sof, e.data, e.sof);
                    end
                end
            end
        end
    end

    task automatic model_data(input bq_t p, input int n);
        logic [31:0] seq;
        seq = {p[4], p[5], p[6], p[7]};
        if (have_last && seq != last_seq + 32'd1 && exp_seq_err < 65535) exp_seq_err++;
        have_last = 1'b1;
        last_seq  = seq;
        for (int f = 0; f < FPP; f++) begin
            int off;
            int avail;
            off   = 8 + 512 * f;
            avail = n - off;
            if (avail > 512) avail = 512;
            if (avail >= 3) begin
                if (p[off] == 8'h7F && p[off+1] == 8'h7F && p[off+2] == 8'h7F) begin
                    for (int w = 0; w < avail / 4; w++) begin
                        exp_t e;
                        e.data = {p[off+4*w], p[off+4*w+1], p[off+4*w+2], p[off+4*w+3]};
                        e.sof  = (w == 0);
                        exp_q.push_back(e);
                        exp_wr++;
                        if (w == 0) exp_sof++;
                    end
                end else if (exp_sync_err < 65535) begin
                    exp_sync_err++;
                end
            end
        end
    endtask

    // Applies the packet rules to the first n bytes the DUT will see.
    task automatic model_pkt(input bq_t p, input logic [15:0] port, input bit bc,
                             input int n, input int unr_at);
        bit unr;
        logic [7:0] arg;
        unr = (unr_at >= 0 && unr_at < n);
        if (unr && unr_at < 3) exp_run = 1'b0;
        if (n >= 3 && port == PORT && p[0] == 8'hEF && p[1] == 8'hFE) begin
            if (p[2] == 8'h02) begin
                exp_disc++;
            end else if (!bc && p[2] == 8'h04 && n >= 4) begin
                arg      = p[3];
                exp_run  = arg[0];
                exp_wide = arg[1];
            end else if (!bc && p[2] == 8'h01 && n >= 8 && p[3] == 8'h02) begin
                model_data(p, n);
            end
        end
        if (unr && unr_at >= 3) exp_run = 1'b0;
    endtask

    function automatic bq_t mk_data(input logic [31:0] seq, input int bad_frame);
        bq_t p;
        p.push_back(8'hEF); p.push_back(8'hFE); p.push_back(8'h01); p.push_back(8'h02);
        p.push_back(seq[31:24]); p.push_back(seq[23:16]); p.push_back(seq[15:8]); p.push_back(seq[7:0]);
        for (int f = 0; f < FPP; f++) begin
            for (int b = 0; b < 512; b++) begin
                if (f == bad_frame && b == 1)  p.push_back(8'h7E);
                else if (b < 3)                p.push_back(8'h7F);
                else if (b == 3)               p.push_back(8'hC0);
                else                           p.push_back(8'($urandom_range(0, 255)));
            end
        end
        return p;
    endfunction

    function automatic bq_t mk_ctl(input logic [7:0] cmd, input logic [7:0] arg, input int len);
        bq_t p;
        p.push_back(8'hEF); p.push_back(8'hFE); p.push_back(cmd); p.push_back(arg);
        while (p.size() < len) p.push_back(8'h00);
        return p;
    endfunction

    task automatic send(input bq_t p, input logic [15:0] port, input bit bc,
                        input int n, input int unr_at);
        model_pkt(p, port, bc, n, unr_at);
        for (int i = 0; i < n; i++) begin
            @(negedge rx_clock);
            rx_valid        = 1'b1;
            rx_data         = p[i];
            to_port         = port;
            broadcast       = bc;
            dst_unreachable = (i == unr_at);
        end
        @(negedge rx_clock);
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        broadcast       = 1'b0;
        dst_unreachable = 1'b0;
        repeat (6) @(negedge rx_clock);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_run"}, 32'(run), 32'(exp_run));
        check({tag, "_wide"}, 32'(wide_spectrum), 32'(exp_wide));
        check({tag, "_seq_err"}, 32'(seq_err_cnt), 32'(exp_seq_err));
        check({tag, "_sync_err"}, 32'(sync_err_cnt), 32'(exp_sync_err));
        check({tag, "_writes"}, 32'(wr_seen), 32'(exp_wr));
        check({tag, "_sofs"}, 32'(sof_seen), 32'(exp_sof));
        check({tag, "_disc"}, 32'(disc_seen), 32'(exp_disc));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_run"}, 32'(run), 32'd0);
        check({tag, "_wide"}, 32'(wide_spectrum), 32'd0);
        check({tag, "_disc_reply"}, 32'(discovery_reply), 32'd0);
        check({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
        check({tag, "_fifo_sof"}, 32'(fifo_sof), 32'd0);
        check({tag, "_fifo_data"}, fifo_data, 32'd0);
        check({tag, "_seq_err"}, 32'(seq_err_cnt), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err_cnt), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bq_t p;
        repeat (3) @(negedge rx_clock);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge rx_clock);

        // Start/stop
        send(mk_ctl(8'h04, 8'h01, 4), PORT, 1'b0, 4, -1);
        check_state("start_run");
        send(mk_ctl(8'h04, 8'h00, 4), PORT, 1'b0, 4, -1);
        check_state("stop");
        send(mk_ctl(8'h04, 8'h02, 4), PORT, 1'b0, 4, -1);
        check_state("wide_only");
        send(mk_ctl(8'h04, 8'h01, 4), 16'd1025, 1'b0, 4, -1);
        check_state("wrong_port");

        // Discovery and broadcast filtering
        send(mk_ctl(8'h02, 8'h00, 63), PORT, 1'b1, 63, -1);
        check_state("discovery");
        send(mk_ctl(8'h04, 8'h01, 4), PORT, 1'b1, 4, -1);
        check_state("bcast_start");

        // EP2 sequence 0,1,3
        p = mk_data(32'd0, -1); send(p, PORT, 1'b0, p.size(), -1);
        p = mk_data(32'd1, -1); send(p, PORT, 1'b0, p.size(), -1);
        p = mk_data(32'd3, -1); send(p, PORT, 1'b0, p.size(), -1);
        check_state("seq_gap");
        check("seq_gap_total_writes", 32'(wr_seen), 32'd768);

        // Bad sync in second frame
        p = mk_data(32'd4, 1); send(p, PORT, 1'b0, p.size(), -1);
        check_state("bad_sync");

        // Abort at byte 300 of the first frame, then a full packet
        p = mk_data(32'd5, -1); send(p, PORT, 1'b0, 8 + 300, -1);
        check_state("abort");
        p = mk_data(32'd6, -1); send(p, PORT, 1'b0, p.size(), -1);
        check_state("after_abort");

        // dst_unreachable clears run
        send(mk_ctl(8'h04, 8'h01, 4), PORT, 1'b0, 4, -1);
        check("run_before_unreach", 32'(run), 32'd1);
        @(negedge rx_clock); dst_unreachable = 1'b1;
        @(negedge rx_clock); dst_unreachable = 1'b0;
        exp_run = 1'b0;
        check("run_after_unreach", 32'(run), 32'(exp_run));
        send(mk_ctl(8'h04, 8'h03, 4), PORT, 1'b0, 4, 3);
        check_state("unreach_vs_start");
        send(mk_ctl(8'h04, 8'h03, 4), PORT, 1'b0, 4, -1);
        check_state("run_wide");

        // Reset in the middle of a frame
        p = mk_data(32'd7, -1);
        model_pkt(p, PORT, 1'b0, 200, -1);
        for (int i = 0; i < 200; i++) begin
            @(negedge rx_clock);
            rx_valid = 1'b1; rx_data = p[i]; to_port = PORT; broadcast = 1'b0;
        end
        @(negedge rx_clock);
        #2 reset_n = 1'b0;
        rx_valid = 1'b0;
        #1 check_zero("async_reset");
        check("reset_queue_drained", 32'(exp_q.size()), 32'd0);
        have_last = 1'b0; exp_seq_err = 0; exp_sync_err = 0; exp_run = 1'b0; exp_wide = 1'b0;
        repeat (2) @(negedge rx_clock);
        reset_n = 1'b1;
        @(negedge rx_clock);
        p = mk_data(32'd100, -1); send(p, PORT, 1'b0, p.size(), -1);
        check_state("post_reset");

        // Randomized mix
        for (int it = 0; it < 10; it++) begin
            int kind;
            int n;
            logic [31:0] s;
            logic [15:0] prt;
            bit bc;
            kind = int'($urandom_range(0, 3));
            prt  = ($urandom_range(0, 5) == 0) ? 16'd2000 : PORT;
            bc   = ($urandom_range(0, 5) == 0);
            if (kind == 0) begin
                s = ($urandom_range(0, 2) == 0 || !have_last) ? $urandom : last_seq + 32'd1;
                p = mk_data(s, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1);
                n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 1031)) : p.size();
                send(p, prt, bc, n, -1);
            end else if (kind == 1) begin
                send(mk_ctl(8'h04, 8'($urandom_range(0, 3)), 8), prt, bc, 8, -1);
            end else if (kind == 2) begin
                send(mk_ctl(8'h02, 8'h00, 63), prt, bc, 63, -1);
            end else begin
                p = {};
                p.push_back(($urandom_range(0, 1) == 0) ? 8'hEF : 8'($urandom_range(0, 255)));
                p.push_back(($urandom_range(0, 3) != 0) ? 8'hFE : 8'($urandom_range(0, 255)));
                p.push_back(8'($urandom_range(0, 5)));
                p.push_back(($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom_range(0, 255)));
                while (p.size() < 20) p.push_back(8'($urandom_range(0, 255)));
                send(p, prt, bc, 20, -1);
            end
            check_state("random");
        end

        repeat (10) @(negedge rx_clock);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_state("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
